// File: rtl/regularization_nch.sv
// N-channel input regularizer: per-channel debounce, programmable hold-off after each toggle,
// optional per-channel bypass, edge strobes and a shared saturating glitch-reject counter.
module regularization_nch #(
  parameter int              N_CH          = 4,
  parameter int              DEBOUNCE_TIME = 2,
  parameter int              DELAY_W       = 8,
  parameter int              CNT_W         = 16,
  parameter logic [N_CH-1:0] INIT          = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_CH-1:0]    i_signal,
  input  logic [DELAY_W-1:0] i_delay,
  input  logic [N_CH-1:0]    i_bypass,
  input  logic               i_clr_cnt,
  output logic [N_CH-1:0]    o_signal,
  output logic [N_CH-1:0]    o_edge,
  output logic [N_CH-1:0]    o_holdoff,
  output logic [CNT_W-1:0]   o_reject_cnt
);

  localparam int            DW      = (DEBOUNCE_TIME > 1) ? $clog2(DEBOUNCE_TIME) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TIME - 1);
  localparam int            PW      = $clog2(N_CH + 1);
  localparam logic [CNT_W:0] REJ_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [N_CH-1:0]              s_q, s_d;
  logic [N_CH-1:0]              sig_q, sig_d;
  logic [N_CH-1:0]              edge_q, edge_d;
  logic [N_CH-1:0][DW-1:0]      cnt_q, cnt_d;
  logic [N_CH-1:0][DELAY_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]             rej_q, rej_d;
  logic [N_CH-1:0]              reject;
  logic [PW-1:0]                n_rej;
  logic [CNT_W:0]               rej_sum;

  always_comb begin
    s_d     = i_signal;
    sig_d   = sig_q;
    edge_d  = '0;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    reject  = '0;
    n_rej   = '0;
    rej_sum = '0;
    rej_d   = rej_q;
    for (int i = 0; i < N_CH; i++) begin
      if (i_bypass[i]) begin
        sig_d[i]  = s_q[i];
        edge_d[i] = s_q[i] ^ sig_q[i];
        cnt_d[i]  = '0;
        hold_d[i] = '0;
      end else if ((s_q[i] != sig_q[i]) && (cnt_q[i] == DB_LAST) && (hold_q[i] == '0)) begin
        sig_d[i]  = s_q[i];
        edge_d[i] = 1'b1;
        cnt_d[i]  = '0;
        hold_d[i] = i_delay;
      end else begin
        if (s_q[i] != sig_q[i]) begin
          // Saturates at the last debounce step so a pending toggle fires as soon as hold-off ends.
          if (cnt_q[i] != DB_LAST) cnt_d[i] = cnt_q[i] + DW'(1);
        end else begin
          reject[i] = (cnt_q[i] != '0);
          cnt_d[i]  = '0;
        end
        if (hold_q[i] != '0) hold_d[i] = hold_q[i] - DELAY_W'(1);
      end
    end
    for (int i = 0; i < N_CH; i++) n_rej = n_rej + PW'(reject[i]);
    rej_sum = {1'b0, rej_q} + (CNT_W + 1)'(n_rej);
    if (i_clr_cnt)             rej_d = '0;
    else if (rej_sum > REJ_MAX) rej_d = {CNT_W{1'b1}};
    else                       rej_d = rej_sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s_q    <= INIT;
      sig_q  <= INIT;
      edge_q <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      rej_q  <= '0;
    end else begin
      s_q    <= s_d;
      sig_q  <= sig_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      rej_q  <= rej_d;
    end
  end

  always_comb begin
    o_holdoff = '0;
    for (int i = 0; i < N_CH; i++) o_holdoff[i] = (hold_q[i] != '0);
  end

  assign o_signal     = sig_q;
  assign o_edge       = edge_q;
  assign o_reject_cnt = rej_q;

endmodule
